// File: rtl/k12_alu_seq.sv
// rtl/k12_alu_seq.sv - issue/writeback sequencer driving an external combinational k12_alu
module k12_alu_seq #(
    parameter int NREGS = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [15:0]              cmd_inst,
    input  logic [$clog2(NREGS)-1:0] cmd_ra,
    input  logic [$clog2(NREGS)-1:0] cmd_rb,
    input  logic [$clog2(NREGS)-1:0] cmd_rd,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [15:0]              alu_inst,
    input  logic [WIDTH-1:0]         alu_res,
    input  logic                     alu_cond,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_res,
    output logic                     rsp_cond,
    output logic                     rsp_err,
    output logic                     flag,
    input  logic                     ld_en,
    input  logic [$clog2(NREGS)-1:0] ld_sel,
    input  logic [WIDTH-1:0]         ld_data,
    input  logic [$clog2(NREGS)-1:0] dbg_sel,
    output logic [WIDTH-1:0]         dbg_data
);
    localparam int SW = $clog2(NREGS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] rf [NREGS];
    logic [SW-1:0]    rd_q;
    logic             err_q;

    assign dbg_data = rf[dbg_sel];

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = EXEC;
            end
            EXEC: state_d = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_inst <= '0;
            rd_q     <= '0;
            err_q    <= 1'b0;
            rsp_res  <= '0;
            rsp_cond <= 1'b0;
            rsp_err  <= 1'b0;
            flag     <= 1'b0;
        end else begin
            state_q <= state_d;
            // Load is assigned first so a same-edge writeback to the same register overrides it.
            if (ld_en) rf[ld_sel] <= ld_data;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a    <= rf[cmd_ra];
                        alu_b    <= rf[cmd_rb];
                        alu_inst <= cmd_inst;
                        rd_q     <= cmd_rd;
                        err_q    <= (cmd_inst[15:14] != 2'b00);
                    end
                end
                EXEC: begin
                    rsp_err <= err_q;
                    if (!err_q) begin
                        rf[rd_q] <= alu_res;
                        flag     <= alu_cond;
                        rsp_res  <= alu_res;
                        rsp_cond <= alu_cond;
                    end else begin
                        rsp_res  <= '0;
                        rsp_cond <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_k12_alu_seq.sv
// tb/tb_k12_alu_seq.sv - directed vector bench for k12_alu_seq with an adder ALU stub
module tb_k12_alu_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_inst;
    logic [2:0]  cmd_ra, cmd_rb, cmd_rd;
    logic [7:0]  alu_a, alu_b;
    logic [15:0] alu_inst;
    logic [7:0]  alu_res;
    logic        alu_cond;
    logic        rsp_valid, rsp_ready;
    logic [7:0]  rsp_res;
    logic        rsp_cond, rsp_err, flag;
    logic        ld_en;
    logic [2:0]  ld_sel;
    logic [7:0]  ld_data;
    logic [2:0]  dbg_sel;
    logic [7:0]  dbg_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // ALU stub: res = a + b, cond = carry out
    assign {alu_cond, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};

    k12_alu_seq dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_inst(cmd_inst),
        .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_inst(alu_inst),
        .alu_res(alu_res), .alu_cond(alu_cond),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_cond(rsp_cond), .rsp_err(rsp_err),
        .flag(flag), .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    typedef struct {
        logic [15:0] inst;
        logic [2:0]  ra, rb, rd;
        logic [7:0]  exp_a, exp_b;
        logic [7:0]  exp_res;
        logic        exp_cond, exp_err, exp_flag;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] sel, input logic [7:0] data);
        ld_en = 1'b1; ld_sel = sel; ld_data = data;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic rd_reg(input logic [2:0] sel, output logic [7:0] val);
        dbg_sel = sel;
        #1;
        val = dbg_data;
    endtask

    task automatic offer(input logic [15:0] inst, input logic [2:0] ra, input logic [2:0] rb,
                         input logic [2:0] rd);
        cmd_valid = 1'b1; cmd_inst = inst; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd;
    endtask

    initial begin
        logic [7:0] v;
        vecs[0] = '{16'h0000, 3'd1, 3'd2, 3'd3, 8'h7E, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 8'h7F};
        vecs[1] = '{16'h0000, 3'd4, 3'd5, 3'd4, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
        vecs[2] = '{16'h4000, 3'd1, 3'd2, 3'd1, 8'h7E, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 8'h7E};
        vecs[3] = '{16'h1234, 3'd3, 3'd3, 3'd3, 8'h7F, 8'h7F, 8'hFE, 1'b0, 1'b0, 1'b0, 8'hFE};
        vecs[4] = '{16'h3FFF, 3'd3, 3'd2, 3'd7, 8'hFE, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF};
        vecs[5] = '{16'hC000, 3'd7, 3'd7, 3'd3, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 8'hFE};

        rst = 1'b1; cmd_valid = 1'b0; cmd_inst = '0; cmd_ra = '0; cmd_rb = '0; cmd_rd = '0;
        rsp_ready = 1'b0; ld_en = 1'b0; ld_sel = '0; ld_data = '0; dbg_sel = '0;

        // reset, with a load in the same cycle that must be ignored
        ld_en = 1'b1; ld_sel = 3'd1; ld_data = 8'h33;
        tick();
        ld_en = 1'b0;
        tick();
        rst = 1'b0;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_flag", flag, 0);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_alu_inst", alu_inst, 0);
        chk("reset_rsp_res", rsp_res, 0);
        for (int i = 0; i < 8; i++) begin
            rd_reg(i[2:0], v);
            chk($sformatf("reset_rf%0d", i), v, 0);
        end

        load(3'd1, 8'h7E);
        load(3'd2, 8'h01);
        load(3'd4, 8'hFF);
        load(3'd5, 8'h01);
        rd_reg(3'd1, v); chk("load_r1", v, 8'h7E);
        rd_reg(3'd2, v); chk("load_r2", v, 8'h01);
        rd_reg(3'd4, v); chk("load_r4", v, 8'hFF);
        chk("load_flag", flag, 0);
        chk("load_rsp_valid", rsp_valid, 0);

        // table-driven ops, rsp_ready high
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            offer(vecs[i].inst, vecs[i].ra, vecs[i].rb, vecs[i].rd);
            chk($sformatf("v%0d_cmd_ready", i), cmd_ready, 1);
            tick();
            cmd_valid = 1'b0;
            chk($sformatf("v%0d_alu_a", i), alu_a, vecs[i].exp_a);
            chk($sformatf("v%0d_alu_b", i), alu_b, vecs[i].exp_b);
            chk($sformatf("v%0d_alu_inst", i), alu_inst, vecs[i].inst);
            chk($sformatf("v%0d_rsp_valid_exec", i), rsp_valid, 0);
            tick();
            chk($sformatf("v%0d_rsp_valid", i), rsp_valid, 1);
            chk($sformatf("v%0d_rsp_res", i), rsp_res, vecs[i].exp_res);
            chk($sformatf("v%0d_rsp_cond", i), rsp_cond, vecs[i].exp_cond);
            chk($sformatf("v%0d_rsp_err", i), rsp_err, vecs[i].exp_err);
            chk($sformatf("v%0d_flag", i), flag, vecs[i].exp_flag);
            tick();
            chk($sformatf("v%0d_rsp_valid_drop", i), rsp_valid, 0);
            rd_reg(vecs[i].rd, v);
            chk($sformatf("v%0d_rd", i), v, vecs[i].exp_rd);
        end

        // backpressure: hold response for 5 cycles while a second command waits
        rsp_ready = 1'b0;
        offer(16'h0000, 3'd1, 3'd2, 3'd5);
        tick();
        offer(16'h0000, 3'd5, 3'd2, 3'd6);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_rsp_valid", i), rsp_valid, 1);
            chk($sformatf("bp%0d_rsp_res", i), rsp_res, 8'h7F);
            chk($sformatf("bp%0d_rsp_err", i), rsp_err, 0);
            chk($sformatf("bp%0d_cmd_ready", i), cmd_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_idle_rsp_valid", rsp_valid, 0);
        chk("bp_idle_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("bp2_alu_a", alu_a, 8'h7F);
        chk("bp2_alu_b", alu_b, 8'h01);
        tick();
        chk("bp2_rsp_res", rsp_res, 8'h80);
        tick();
        rd_reg(3'd6, v); chk("bp2_r6", v, 8'h80);

        // reset asserted while in EXEC
        offer(16'h0000, 3'd1, 3'd2, 3'd0);
        tick();
        cmd_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midrst%0d_rsp_valid", i), rsp_valid, 0);
            tick();
        end
        chk("midrst_flag", flag, 0);
        for (int i = 0; i < 8; i++) begin
            rd_reg(i[2:0], v);
            chk($sformatf("midrst_rf%0d", i), v, 0);
        end

        // load collisions: operand load at accept edge, destination load at EXEC edge
        load(3'd1, 8'h50);
        load(3'd2, 8'h05);
        offer(16'h0000, 3'd1, 3'd2, 3'd3);
        ld_en = 1'b1; ld_sel = 3'd1; ld_data = 8'h10;
        tick();
        cmd_valid = 1'b0;
        chk("col_alu_a_old", alu_a, 8'h50);
        ld_sel = 3'd3; ld_data = 8'hAA;
        tick();
        ld_en = 1'b0;
        chk("col_rsp_res", rsp_res, 8'h55);
        tick();
        rd_reg(3'd3, v); chk("col_r3_wb_wins", v, 8'h55);
        rd_reg(3'd1, v); chk("col_r1_loaded", v, 8'h10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
